// File: rtl/edge_event_capture.sv
// Per-channel edge detector: synchroniser, glitch filter, registered edge strobe and sticky pending flag.
// Optional per-channel saturating event counters are compiled in with EDGE_EVENT_COUNT_EN.
module edge_event_capture #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [CHANNELS-1:0]     in,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     clear,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     pulse,
  output logic [CHANNELS-1:0]     pending,
  output logic                    any_pending
`ifdef EDGE_EVENT_COUNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] count
`endif
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 || FILTER_LEN < 1 || CNT_W < 1) begin : g_param_err
    $error("edge_event_capture: illegal parameter value");
  end

  // Stage 0 is the newest sample; the last stage feeds the filter.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][FW-1:0]          filt_q, filt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic [CHANNELS-1:0]                  pending_q, pending_d;
  logic [CHANNELS-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], in};
    filt_d    = filt_q;
    level_d   = level_q;
    pulse_d   = '0;
    pending_d = pulse_q | (pending_q & ~clear);
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_last[i] != level_q[i]) begin
        if (filt_q[i] == FILT_LAST) begin
          filt_d[i]  = '0;
          level_d[i] = sync_last[i];
          // Mode is taken at the accepting edge, so a mode change only affects later acceptances.
          pulse_d[i] = sync_last[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          filt_d[i] = filt_q[i] + FW'(1);
        end
      end else begin
        filt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= '0;
      filt_q    <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign level       = level_q;
  assign pulse       = pulse_q;
  assign pending     = pending_q;
  assign any_pending = |pending_q;

`ifdef EDGE_EVENT_COUNT_EN
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear and a simultaneous event leave exactly that one event counted.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        cnt_d[i] = pulse_q[i] ? CNT_W'(1) : '0;
      end else if (pulse_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
`endif

endmodule

// File: tb/tb_edge_event_capture.sv
// Bench for edge_event_capture: directed vector table, hand sequences for reset/mode corners,
// and a randomized run against a sample-history reference model.
module tb_edge_event_capture;

  localparam int CH = 4;
  localparam int S  = 2;
  localparam int F  = 4;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [CH-1:0]     in_r = '0;
  logic [2*CH-1:0]   mode_r = '0;
  logic [CH-1:0]     clear_r = '0;
  logic [CH-1:0]     level, pulse, pending;
  logic              any_pending;
`ifdef EDGE_EVENT_COUNT_EN
  logic [CH*CW-1:0]  count;
`endif

  always #5 clk = ~clk;

  edge_event_capture #(
    .CHANNELS(CH), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in(in_r),
    .mode(mode_r),
    .clear(clear_r),
    .level(level),
    .pulse(pulse),
    .pending(pending),
    .any_pending(any_pending)
`ifdef EDGE_EVENT_COUNT_EN
    ,
    .count(count)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: level flips when the last F synchronised samples all disagree with it.
  // hist[0] is the newest raw sample; the synchronised value is S samples old.
  logic [CH-1:0] hist [S+F];
  logic [CH-1:0] m_level, m_pulse, m_pend;
  int            m_cnt [CH];

  function automatic logic [CH-1:0] accept_now();
    logic [CH-1:0] a;
    a = '1;
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < F; j++)
        if (hist[S-1+j][c] == m_level[c]) a[c] = 1'b0;
    return a;
  endfunction

  function automatic logic [CH-1:0] pulse_of(input logic [CH-1:0] a);
    logic [CH-1:0] p;
    p = '0;
    for (int c = 0; c < CH; c++)
      p[c] = a[c] && (m_level[c] ? mode_r[2*c+1] : mode_r[2*c]);
    return p;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < S+F; k++) hist[k] <= '0;
      m_level <= '0;
      m_pulse <= '0;
      m_pend  <= '0;
      for (int c = 0; c < CH; c++) m_cnt[c] <= 0;
    end else begin
      m_pend <= m_pulse | (m_pend & ~clear_r);
      for (int c = 0; c < CH; c++) begin
        if (clear_r[c]) m_cnt[c] <= m_pulse[c] ? 1 : 0;
        else if (m_pulse[c]) m_cnt[c] <= (m_cnt[c] + 1 > 2**CW - 1) ? 2**CW - 1 : m_cnt[c] + 1;
      end
      m_pulse <= pulse_of(accept_now());
      m_level <= m_level ^ accept_now();
      hist[0] <= in_r;
      for (int k = 1; k < S+F; k++) hist[k] <= hist[k-1];
    end
  end

  typedef struct {
    logic [7:0] mode;
    logic [3:0] in;
    logic [3:0] clr;
    int         wait_n;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] pnd;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check_outputs(input string tag, input logic [3:0] lvl, input logic [3:0] pls,
                               input logic [3:0] pnd);
    chk({tag, " level"}, level, lvl);
    chk({tag, " pulse"}, pulse, pls);
    chk({tag, " pending"}, pending, pnd);
    chk({tag, " any_pending"}, any_pending, |pnd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0 rising, ch1 both, ch2 falling, ch3 both
    vecs[0]  = '{8'hED, 4'b0000, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{8'hED, 4'b0001, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{8'hED, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000};
    vecs[3]  = '{8'hED, 4'b0001, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0001};
    vecs[4]  = '{8'hED, 4'b0001, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    vecs[5]  = '{8'hED, 4'b0011, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000};
    vecs[6]  = '{8'hED, 4'b0001, 4'b0000, 8, 4'b0001, 4'b0000, 4'b0000};
    vecs[7]  = '{8'hED, 4'b0101, 4'b0000, 6, 4'b0101, 4'b0000, 4'b0000};
    vecs[8]  = '{8'hED, 4'b0101, 4'b0000, 4, 4'b0101, 4'b0000, 4'b0000};
    vecs[9]  = '{8'hED, 4'b0001, 4'b0000, 6, 4'b0001, 4'b0100, 4'b0000};
    vecs[10] = '{8'hED, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0100};
    vecs[11] = '{8'hED, 4'b0001, 4'b0100, 1, 4'b0001, 4'b0000, 4'b0000};
    vecs[12] = '{8'hFD, 4'b0101, 4'b0000, 6, 4'b0101, 4'b0100, 4'b0000};
    vecs[13] = '{8'hFD, 4'b0101, 4'b0000, 1, 4'b0101, 4'b0000, 4'b0100};
    vecs[14] = '{8'hFD, 4'b0001, 4'b0000, 4, 4'b0101, 4'b0000, 4'b0100};
    vecs[15] = '{8'hFD, 4'b0001, 4'b0000, 2, 4'b0001, 4'b0100, 4'b0100};
    vecs[16] = '{8'hFD, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0100};
    vecs[17] = '{8'hFD, 4'b0001, 4'b0100, 1, 4'b0001, 4'b0000, 4'b0000};
    vecs[18] = '{8'h3D, 4'b1001, 4'b0000, 6, 4'b1001, 4'b0000, 4'b0000};
    vecs[19] = '{8'h3D, 4'b1001, 4'b0000, 2, 4'b1001, 4'b0000, 4'b0000};
    vecs[20] = '{8'h3D, 4'b0001, 4'b0000, 6, 4'b0001, 4'b0000, 4'b0000};
    vecs[21] = '{8'hFF, 4'b1110, 4'b0000, 6, 4'b1110, 4'b1111, 4'b0000};
    vecs[22] = '{8'hFF, 4'b1110, 4'b0000, 1, 4'b1110, 4'b0000, 4'b1111};
    vecs[23] = '{8'hFF, 4'b1110, 4'b1111, 1, 4'b1110, 4'b0000, 4'b0000};

    // Reset state, with activity on the inputs that must not leak through.
    resetn = 1'b0;
    in_r   = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 4'b0000, 4'b0000, 4'b0000);
    in_r   = 4'b0000;
    resetn = 1'b1;

    for (int v = 0; v < NV; v++) begin
      mode_r  = vecs[v].mode;
      in_r    = vecs[v].in;
      clear_r = vecs[v].clr;
      repeat (vecs[v].wait_n) @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].pls, vecs[v].pnd);
    end
    clear_r = '0;

    // Reset asserted mid-filter on ch3 while other channels hold pending bits.
    mode_r = 8'hFF;
    in_r   = 4'b0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_outputs("pre_reset", 4'b0000, 4'b0000, 4'b1110);
    in_r = 4'b1000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midfilter level", level, 4'b0000);
    #2;
    resetn = 1'b0;
    in_r   = 4'b0000;
    #1;
    check_outputs("async_reset", 4'b0000, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d level/pulse", k), {level, pulse}, 8'h00);
    end

    // Input held high through reset release is accepted after the full latency.
    resetn = 1'b0;
    in_r   = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("release+5 level", level, 4'b0000);
    @(negedge clk);
    check_outputs("release+6", 4'b1111, 4'b1111, 4'b0000);
    @(negedge clk);
    check_outputs("release+7", 4'b1111, 4'b0000, 4'b1111);
    clear_r = 4'b1111;
    @(negedge clk);
    clear_r = '0;

    // Mode sampled at the accepting edge, not when the filter started.
    mode_r = 8'hFC;
    in_r   = 4'b1110;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mode_r = 8'hFE;
    @(negedge clk);
    chk("mode_late_enable pulse", pulse, 4'b0001);
    mode_r = 8'hFD;
    in_r   = 4'b1111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mode_r = 8'hFC;
    @(negedge clk);
    chk("mode_late_disable pulse", pulse, 4'b0000);
    chk("mode_late_disable level", level, 4'b1111);

`ifdef EDGE_EVENT_COUNT_EN
    resetn = 1'b0;
    in_r   = '0;
    mode_r = 8'hFF;
    @(negedge clk);
    resetn = 1'b1;
    for (int t = 0; t < 300; t++) begin
      in_r[0] = ~in_r[0];
      repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("count saturate", count[CW-1:0], 8'd255);
    clear_r = 4'b0001;
    @(negedge clk);
    clear_r = '0;
    @(negedge clk);
    chk("count clear", count[CW-1:0], 8'd0);
`endif

    // Randomized run against the reference model.
    resetn  = 1'b0;
    in_r    = '0;
    clear_r = '0;
    mode_r  = 8'($urandom);
    @(negedge clk);
    resetn = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd level", level, m_level);
      chk("rnd pulse", pulse, m_pulse);
      chk("rnd pending", pending, m_pend);
      chk("rnd any_pending", any_pending, |m_pend);
`ifdef EDGE_EVENT_COUNT_EN
      for (int c = 0; c < CH; c++)
        chk($sformatf("rnd count%0d", c), count[c*CW +: CW], m_cnt[c]);
`endif
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) in_r[c] = ~in_r[c];
        clear_r[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 31) == 0) mode_r = 8'($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
